// File: rtl/game_pkg.sv
// Shared game-state codes and 7-segment encodings (active-low gfedcba) for the score path.
package game_pkg;

  localparam logic [1:0] GAME_INIT  = 2'd0;
  localparam logic [1:0] GAME_START = 2'd1;
  localparam logic [1:0] GAME_END   = 2'd2;
  localparam logic [1:0] GAME_RESET = 2'd3;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;
  localparam logic [6:0] SEG_TWO   = 7'b0100100;
  localparam logic [6:0] SEG_THREE = 7'b0110000;
  localparam logic [6:0] SEG_FOUR  = 7'b0011001;
  localparam logic [6:0] SEG_FIVE  = 7'b0010010;
  localparam logic [6:0] SEG_SIX   = 7'b0000010;
  localparam logic [6:0] SEG_SEVEN = 7'b1111000;
  localparam logic [6:0] SEG_EIGHT = 7'b0000000;
  localparam logic [6:0] SEG_NINE  = 7'b0010000;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    unique case (digit)
      4'd0:    seg = SEG_ZERO;
      4'd1:    seg = SEG_ONE;
      4'd2:    seg = SEG_TWO;
      4'd3:    seg = SEG_THREE;
      4'd4:    seg = SEG_FOUR;
      4'd5:    seg = SEG_FIVE;
      4'd6:    seg = SEG_SIX;
      4'd7:    seg = SEG_SEVEN;
      4'd8:    seg = SEG_EIGHT;
      4'd9:    seg = SEG_NINE;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the score chain; carry_out is combinational so a whole
// chain of digits rolls over on a single edge.
module bcd_digit_counter (
  input  logic       game_clk,
  input  logic       rst,
  input  logic       inc_in,
  input  logic       clear,
  output logic [3:0] value,
  output logic       carry_out,
  output logic       is_nine
);

  logic [3:0] value_q, value_d;

  assign is_nine   = (value_q == 4'd9);
  assign carry_out = inc_in & is_nine;
  assign value     = value_q;

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = 4'd0;
    end else if (inc_in) begin
      value_d = is_nine ? 4'd0 : value_q + 4'd1;
    end
  end

  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/score_keeper_bcd.sv
// BCD score / high-score keeper with prescaled increment, record detection and a
// registered 7-segment display of either value.
module score_keeper_bcd
  import game_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned TICK_DIV       = 20,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  game_clk,
  input  logic                  rst,
  input  logic [1:0]            game_state,
  input  logic                  mode,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   high_score,
  output logic [7*DIGITS-1:0]   display_all,
  output logic                  new_record,
  output logic                  saturated
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [6:0]    ZERO_POL  = SEG_ACTIVE_LOW ? SEG_ZERO : ~SEG_ZERO;

  logic [PW-1:0]          presc_q, presc_d;
  logic [4*DIGITS-1:0]    high_q, high_d;
  logic [7*DIGITS-1:0]    disp_q, disp_d;
  logic [1:0]             prev_q;
  logic                   nr_q, nr_d;
  logic                   sat_q, sat_d;
  logic                   tick, clear, all_nines;
  logic [DIGITS:0]        carry;
  logic [DIGITS-1:0]      nine;
  logic [4*DIGITS-1:0]    disp_sel;
  logic                   unused_carry;

  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (game_state == GAME_START) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else if (game_state == GAME_RESET) begin
      presc_d = '0;
    end
  end

  assign clear     = (game_state == GAME_RESET);
  assign all_nines = &nine;
  // A tick at all-nines is swallowed so the score sticks instead of wrapping.
  assign carry[0]  = tick & ~all_nines;
  assign unused_carry = carry[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_counter u_digit (
      .game_clk  (game_clk),
      .rst       (rst),
      .inc_in    (carry[g]),
      .clear     (clear),
      .value     (score[4*g +: 4]),
      .carry_out (carry[g+1]),
      .is_nine   (nine[g])
    );
  end

  always_comb begin
    sat_d  = sat_q;
    high_d = high_q;
    nr_d   = nr_q;
    if (game_state == GAME_RESET) begin
      sat_d = 1'b0;
      nr_d  = 1'b0;
    end else if (tick && all_nines) begin
      sat_d = 1'b1;
    end
    // Packed BCD digits compare correctly as a plain unsigned vector (MSD first).
    if (game_state == GAME_END && prev_q != GAME_END && score > high_q) begin
      high_d = score;
      nr_d   = 1'b1;
    end
  end

  always_comb begin
    disp_sel = mode ? high_q : score;
    disp_d   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      disp_d[7*i +: 7] = SEG_ACTIVE_LOW ? bcd_to_seg(disp_sel[4*i +: 4])
                                        : ~bcd_to_seg(disp_sel[4*i +: 4]);
    end
  end

  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      high_q  <= '0;
      nr_q    <= 1'b0;
      sat_q   <= 1'b0;
      prev_q  <= GAME_INIT;
      disp_q  <= {DIGITS{ZERO_POL}};
    end else begin
      presc_q <= presc_d;
      high_q  <= high_d;
      nr_q    <= nr_d;
      sat_q   <= sat_d;
      prev_q  <= game_state;
      disp_q  <= disp_d;
    end
  end

  assign high_score  = high_q;
  assign new_record  = nr_q;
  assign saturated   = sat_q;
  assign display_all = disp_q;

endmodule

// File: tb/tb_score_keeper_bcd.sv
// Directed bench for score_keeper_bcd: one TICK_DIV=20 instance for the game flow and a
// TICK_DIV=1 instance for saturation.
module tb_score_keeper_bcd;

  logic        game_clk = 1'b0;
  logic        rst;
  logic [1:0]  game_state, game_state1;
  logic        mode;
  logic [15:0] score, high_score, score1, high_score1;
  logic [27:0] display_all, display_all1;
  logic        new_record, saturated, new_record1, saturated1;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [6:0]  Z     = 7'b1000000;
  localparam logic [6:0]  ONE   = 7'b1111001;
  localparam logic [6:0]  SEVEN = 7'b1111000;
  localparam logic [27:0] ZERO4 = {Z, Z, Z, Z};

  always #5 game_clk = ~game_clk;

  score_keeper_bcd #(.DIGITS(4), .TICK_DIV(20), .SEG_ACTIVE_LOW(1'b1)) dut (
    .game_clk    (game_clk),
    .rst         (rst),
    .game_state  (game_state),
    .mode        (mode),
    .score       (score),
    .high_score  (high_score),
    .display_all (display_all),
    .new_record  (new_record),
    .saturated   (saturated)
  );

  score_keeper_bcd #(.DIGITS(4), .TICK_DIV(1), .SEG_ACTIVE_LOW(1'b1)) dut1 (
    .game_clk    (game_clk),
    .rst         (rst),
    .game_state  (game_state1),
    .mode        (1'b0),
    .score       (score1),
    .high_score  (high_score1),
    .display_all (display_all1),
    .new_record  (new_record1),
    .saturated   (saturated1)
  );

  task automatic step(input int n);
    repeat (n) @(posedge game_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; game_state = 2'd0; game_state1 = 2'd0; mode = 1'b0;
    step(2);
    check("rst_score", 32'(score), 32'h0);
    check("rst_high", 32'(high_score), 32'h0);
    check("rst_flags", {30'd0, new_record, saturated}, 32'h0);
    check("rst_disp", 32'(display_all), 32'(ZERO4));
    rst = 1'b0;

    // Saturation on the TICK_DIV=1 instance
    game_state1 = 2'd1;
    step(9999);
    check("sat_pre_score", 32'(score1), 32'h9999);
    check("sat_pre_flag", 32'(saturated1), 32'h0);
    step(1);
    check("sat_score", 32'(score1), 32'h9999);
    check("sat_flag", 32'(saturated1), 32'h1);
    game_state1 = 2'd3;
    step(1);
    check("sat_reset", {15'd0, saturated1, score1}, 32'h0);
    game_state1 = 2'd0;
    check("init_hold_main", 32'(score), 32'h0);

    // First tick and display latency
    game_state = 2'd1;
    step(20);
    check("tick20_score", 32'(score), 32'h0001);
    check("tick20_disp_lag", 32'(display_all), 32'(ZERO4));
    step(1);
    check("disp_one", 32'(display_all), 32'({Z, Z, Z, ONE}));
    step(1978);
    check("score_99", 32'(score), 32'h0099);
    step(1);
    check("ripple_100", 32'(score), 32'h0100);
    game_state = 2'd0;
    step(50);
    check("init_hold", 32'(score), 32'h0100);

    // First game to 42: record
    game_state = 2'd3; step(1);
    check("reset_score", 32'(score), 32'h0);
    game_state = 2'd1; step(840);
    check("game1_score", 32'(score), 32'h0042);
    check("game1_no_high_yet", 32'(high_score), 32'h0);
    game_state = 2'd2; step(1);
    check("game1_high", 32'(high_score), 32'h0042);
    check("game1_record", 32'(new_record), 32'h1);
    step(3);
    check("end_stay_score", 32'(score), 32'h0042);
    game_state = 2'd3; step(1);
    check("reset2_score", 32'(score), 32'h0);
    check("reset2_nr", 32'(new_record), 32'h0);
    check("reset2_high", 32'(high_score), 32'h0042);

    // Second game equal: not a record
    game_state = 2'd1; step(840);
    game_state = 2'd2; step(1);
    check("equal_high", 32'(high_score), 32'h0042);
    check("equal_nr", 32'(new_record), 32'h0);

    // Game to 98, then 107
    game_state = 2'd3; step(1);
    game_state = 2'd1; step(1960);
    game_state = 2'd2; step(1);
    check("game98_high", 32'(high_score), 32'h0098);
    game_state = 2'd3; step(1);
    game_state = 2'd1; step(2140);
    check("game107_score", 32'(score), 32'h0107);
    game_state = 2'd2; step(1);
    check("game107_high", 32'(high_score), 32'h0107);
    check("game107_nr", 32'(new_record), 32'h1);
    game_state = 2'd3; mode = 1'b1; step(1);
    check("disp_high", 32'(display_all), 32'({Z, ONE, Z, SEVEN}));
    check("disp_high_score0", 32'(score), 32'h0);
    mode = 1'b0; step(1);
    check("disp_score0", 32'(display_all), 32'(ZERO4));

    // Asynchronous reset mid-game
    game_state = 2'd1; step(700);
    check("mid_score", 32'(score), 32'h0035);
    #2 rst = 1'b1; #1;
    check("async_score", 32'(score), 32'h0);
    check("async_high", 32'(high_score), 32'h0);
    check("async_flags", {30'd0, new_record, saturated}, 32'h0);
    step(1);
    check("async_disp", 32'(display_all), 32'(ZERO4));
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/score_keeper_bcd.md
Name: score_keeper_bcd

Overview:
Parametrised successor to the game score counter, sitting between the game FSM and the 7-segment display driver.
- Keeps the running score and the high score as BCD digit chains, so no dividers are needed.
- Latches the high score when a game ends and flags a new record.
- Drives registered 7-segment patterns for either value, selected by `mode`.

Parameters:
- DIGITS, 4: number of BCD digits held and displayed (1..8).
- TICK_DIV, 20: `game_clk` cycles in GAME_START per score increment (>=1).
- SEG_ACTIVE_LOW, 1: 1 = segment patterns active-low (gfedcba); 0 = bitwise inverted.

Ports:
- game_clk  in  1  game clock; all state updates on the rising edge.
- rst  in  1  reset.
- game_state  in  2  0=INIT, 1=START, 2=END, 3=RESET.
- mode  in  1  0 = display score, 1 = display high score.
- score  out  4*DIGITS  running score, BCD; digit 0 = LSD in [3:0].
- high_score  out  4*DIGITS  best score, BCD.
- display_all  out  7*DIGITS  segment patterns; MSD in the top 7 bits.
- new_record  out  1  high when the last game beat the previous high score.
- saturated  out  1  score is stuck at all-nines.

Behaviour:
- Reset: `rst` is asynchronous, active-high; clock is `game_clk`.
  - rst=1 clears: score, high_score, the prescaler, new_record, saturated, and the prev_state register (which takes INIT).
  - display_all resets to the ZERO pattern in every digit: 7'b1000000 per digit when SEG_ACTIVE_LOW=1.
- Prescaler: counter width is clog2(TICK_DIV), with a minimum of 1 bit.
  - Counts only while game_state==START.
  - On reaching TICK_DIV-1 it wraps to 0 and issues a one-cycle tick.
  - With TICK_DIV=1, every START cycle is a tick.
- Score increment: on a tick, score += 1 in BCD. Each digit wraps 9->0 with a carry to the next digit; the carry ripples combinationally within the same cycle.
- Saturation: if score is all-nines when a tick occurs, score holds and saturated goes to 1 on that edge. The prescaler keeps running.
- START holds high_score and new_record.
- END:
  - Score and prescaler freeze.
  - On the first END cycle (prev_state != END), if score > high_score then high_score <= score and new_record <= 1; otherwise both hold.
  - The comparison is a BCD magnitude compare: MSD-first lexicographic, equivalent to unsigned compare.
  - Equal scores are not a record.
  - Staying in END causes no re-evaluation.
- RESET: score, prescaler, saturated and new_record clear to 0. high_score is retained.
- INIT: all state holds.
- prev_state <= game_state every cycle.
- Display:
  - display_all is registered, 1-cycle latency from score/high_score/mode.
  - Digit values 0-9 map to the ZERO..NINE patterns.
  - Digit codes 10-15 cannot occur and map to the all-off pattern.
  - mode may toggle in any state; the display follows one cycle later.
- Simultaneous events:
  - The START->END edge: the compare uses the score registered at that edge, which includes any tick on the final START cycle.
  - A direct START->RESET or START->INIT transition never updates high_score.
  - Undefined game_state values are impossible with 2 bits.
- rst mid-game: immediate clear of all state, including high_score; no record is taken.

Decomposition:
- Package `game_pkg`:
  - game state codes GAME_INIT/START/END/RESET;
  - 7-segment constants SEG_ZERO..SEG_NINE and SEG_OFF;
  - function bcd_to_seg(4-bit) -> 7-bit.
- Sub-module `bcd_digit_counter`: one digit with inc_in, clear, carry_out and a value==9 flag. Instantiate DIGITS times in a generate chain.
- The BCD compare, prescaler and display register stay in the top module.

Test Plan (DIGITS=4, TICK_DIV=20 unless noted):
- rst, then START for 20 cycles -> score 0x0001 after the 20th edge. Display digit 0 shows 7'b1111001 one cycle later; the other digits show 7'b1000000.
- START 2000 cycles -> score 0x0100, checking the carry ripple 0x0099 -> 0x0100 on a single tick edge.
- TICK_DIV=1: preload by running START to 0x9999, then tick once more -> score stays 0x9999 and saturated=1.
- Game to 0x0042, then END -> high_score=0x0042 and new_record=1. RESET -> score 0, new_record=0, high_score 0x0042. Second game to 0x0042, END -> high_score unchanged and new_record=0 (equal is not a record).
- Second game reaches 0x0107 vs high 0x0098 -> high_score=0x0107. Set mode=1 -> display_all shows 1,0,7 in the low three digits one cycle later.
- Assert rst for one cycle mid-START at score 0x0035 -> score, high_score and flags all 0 immediately (asynchronous), display back to ZERO on the next edge.
